// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared SRAM command encodings for GF180 single-port macro clients.
// Any block driving CEN/GWEN/WEN can reuse these instead of hand-coding polarities.
package sram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE  = 2'd0,
    SRAM_READ  = 2'd1,
    SRAM_WRITE = 2'd2
  } sram_cmd_e;

  // All macro controls are active low; wen_bit is replicated across the byte.
  typedef struct packed {
    logic cen;
    logic gwen;
    logic wen_bit;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE  = '{cen: 1'b1, gwen: 1'b1, wen_bit: 1'b1};
  localparam sram_ctl_t SRAM_CTL_READ  = '{cen: 1'b0, gwen: 1'b1, wen_bit: 1'b1};
  localparam sram_ctl_t SRAM_CTL_WRITE = '{cen: 1'b0, gwen: 1'b0, wen_bit: 1'b0};

  localparam int OBUF_DEPTH = 2;

  function automatic sram_ctl_t sram_ctl(input sram_cmd_e cmd);
    case (cmd)
      SRAM_WRITE: return SRAM_CTL_WRITE;
      SRAM_READ:  return SRAM_CTL_READ;
      default:    return SRAM_CTL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer absorbing the SRAM read latency.
// Head is registered and drives out_data directly; capture and pop may coincide.
module sram_fifo_obuf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          capture,
  input  logic [DW-1:0] cap_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_count;
  logic          w_pop;

  assign w_pop = pop && (r_count != 2'd0);
  assign head  = r_head;
  assign count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({capture, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= cap_data;
          else                 r_tail <= cap_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and capture: the buffer shifts and refills, count holds.
          if (r_count == 2'd1) begin
            r_head <= cap_data;
          end else begin
            r_head <= r_tail;
            r_tail <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Byte FIFO controller over one single-port 512x8 SRAM macro.
// Arbitrates one write or one read command per cycle and prefetches into a 2-entry buffer.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] level,
  output logic          sram_cen,
  output logic          sram_gwen,
  output logic [DW-1:0] sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_count;
  logic          r_rd_inflight;
  logic          r_prio_rd;
  logic          r_run;
  logic [AW+1:0] r_level;

  logic [1:0]    w_ob_count;
  logic [2:0]    w_pending;
  logic          w_read_want;
  logic          w_space;
  logic          w_wr;
  logic          w_rd;
  logic          w_contend;
  logic          w_pop;
  logic          w_capture;
  logic [AW:0]   w_mem_count_next;
  logic [AW+1:0] w_level_next;
  sram_cmd_e     w_cmd;
  sram_ctl_t     w_ctl;

  assign w_pending   = {1'b0, w_ob_count} + {2'b00, r_rd_inflight};
  assign w_read_want = r_run && (r_mem_count != '0) && (w_pending < 3'd2);
  // mem_count never exceeds 2**AW, so its top bit alone marks "full".
  assign w_space     = r_run && !r_mem_count[AW];

  assign in_ready  = w_space && !(w_read_want && r_prio_rd) && !flush;
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = w_read_want && !w_wr && !flush;
  assign w_contend = w_read_want && in_valid && w_space && !flush;

  assign out_valid = (w_ob_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_rd_inflight;

  always_comb begin
    w_cmd = SRAM_IDLE;
    if (w_wr)      w_cmd = SRAM_WRITE;
    else if (w_rd) w_cmd = SRAM_READ;
  end

  assign w_ctl     = sram_ctl(w_cmd);
  assign sram_cen  = w_ctl.cen;
  assign sram_gwen = w_ctl.gwen;
  assign sram_wen  = {DW{w_ctl.wen_bit}};
  assign sram_a    = w_wr ? r_wr_ptr : r_rd_ptr;
  assign sram_d    = w_wr ? in_data : '0;

  always_comb begin
    w_mem_count_next = r_mem_count;
    if (w_wr)      w_mem_count_next = r_mem_count + (AW+1)'(1);
    else if (w_rd) w_mem_count_next = r_mem_count - (AW+1)'(1);
  end

  // Level tracks every stage a byte can occupy, so it is exact even mid-read.
  assign w_level_next = (AW+2)'(w_mem_count_next) + (AW+2)'(w_rd)
                      + (AW+2)'(w_ob_count) + (AW+2)'(w_capture)
                      - (AW+2)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mem_count   <= '0;
      r_rd_inflight <= 1'b0;
      r_prio_rd     <= 1'b0;
      r_level       <= '0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_mem_count   <= '0;
        r_rd_inflight <= 1'b0;
        r_prio_rd     <= 1'b0;
        r_level       <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_contend) r_prio_rd <= !r_prio_rd;
        r_mem_count   <= w_mem_count_next;
        r_rd_inflight <= w_rd;
        r_level       <= w_level_next;
      end
    end
  end

  assign level = r_level;

  sram_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .capture  (w_capture),
    .cap_data (sram_q),
    .pop      (w_pop),
    .head     (out_data),
    .count    (w_ob_count)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural SRAM macro
// and a queue-based reference model of the FIFO.
module tb_sram_fifo_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Behavioural macro: Q valid only the cycle after a read, junk otherwise.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_cen && !sram_gwen)
      sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    if (!sram_cen && sram_gwen) sram_q <= sram_mem[sram_a];
    else                        sram_q <= 8'($urandom);
  end

  // Reference model: byte queues for memory, in-flight slot and output buffer.
  logic [7:0] m_mem[$];
  logic [7:0] m_ob[$];
  logic       m_infl, m_run, m_prio;
  logic [7:0] m_infl_byte;
  int         m_wrp, m_rdp;

  logic       e_in_ready, e_cen, e_gwen, e_out_valid, e_is_read, e_is_write;
  logic [8:0] e_a;
  logic [7:0] e_d, e_out_data;
  int         e_level, e_pend;

  logic       o_in_ready, o_cen, o_gwen, o_out_valid;
  logic [7:0] o_wen, o_d, o_out_data;
  logic [8:0] o_a;
  int         o_level;

  task automatic model_reset();
    m_mem.delete(); m_ob.delete();
    m_infl = 1'b0; m_run = 1'b0; m_prio = 1'b0; m_infl_byte = 8'h00;
    m_wrp = 0; m_rdp = 0;
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic rw, sp, wr, rd;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    o_in_ready = in_ready; o_cen = sram_cen; o_gwen = sram_gwen; o_wen = sram_wen;
    o_a = sram_a; o_d = sram_d; o_out_valid = out_valid; o_out_data = out_data;
    o_level = int'(level);
    rw = m_run && (m_mem.size() != 0) && ((m_ob.size() + int'(m_infl)) < 2);
    sp = m_run && (m_mem.size() < 512);
    e_in_ready = !fl && sp && !(rw && m_prio);
    wr = iv && e_in_ready;
    rd = !fl && !wr && rw;
    e_is_write = wr; e_is_read = rd;
    e_cen = !(wr || rd); e_gwen = !wr;
    e_a = wr ? 9'(m_wrp) : 9'(m_rdp);
    e_d = id;
    e_pend = m_ob.size() + int'(m_infl);
    e_out_valid = (m_ob.size() != 0);
    e_out_data = e_out_valid ? m_ob[0] : 8'h00;
    e_level = m_mem.size() + m_ob.size() + int'(m_infl);
    @(posedge clk);
    if (fl) begin
      m_mem.delete(); m_ob.delete();
      m_infl = 1'b0; m_prio = 1'b0; m_wrp = 0; m_rdp = 0;
    end else begin
      if (rw && iv && sp) m_prio = !m_prio;
      if (e_out_valid && ordy) void'(m_ob.pop_front());
      if (m_infl) m_ob.push_back(m_infl_byte);
      if (wr) begin m_mem.push_back(id); m_wrp = (m_wrp + 1) % 512; end
      m_infl = rd;
      if (rd) begin m_infl_byte = m_mem.pop_front(); m_rdp = (m_rdp + 1) % 512; end
    end
    m_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (level !== 11'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 8'hFF) begin
      n_fail++; $display("FAIL reset_sram_ctl got cen=%0b gwen=%0b wen=%h exp 1/1/ff", sram_cen, sram_gwen, sram_wen);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_in_ready got=%0b exp=0", o_in_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_second_cycle_in_ready got=%0b exp=1", o_in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    n_cmp++; if (o_cen !== 1'b0 || o_gwen !== 1'b0 || o_wen !== 8'h00 || o_a !== 9'd0 || o_d !== 8'h5A) begin
      n_fail++; $display("FAIL single_write got cen=%0b gwen=%0b wen=%h a=%0d d=%h exp 0/0/00/0/5a", o_cen, o_gwen, o_wen, o_a, o_d);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_cen !== 1'b0 || o_gwen !== 1'b1 || o_a !== 9'd0) begin
      n_fail++; $display("FAIL single_read got cen=%0b gwen=%0b a=%0d exp 0/1/0", o_cen, o_gwen, o_a);
    end
    n_cmp++; if (o_level !== 1) begin n_fail++; $display("FAIL single_level_c1 got=%0d exp=1", o_level); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%0b exp=0", o_out_valid); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h5A) begin
      n_fail++; $display("FAIL single_out got valid=%0b data=%h exp 1/5a", o_out_valid, o_out_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_level !== 0 || o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_after_pop got level=%0d valid=%0b exp 0/0", o_level, o_out_valid);
    end
    $display("test_single done");
  endtask

  task automatic test_fill();
    int acc = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 1500 && acc < 514; c++) begin
      step(1'b1, 8'(acc), 1'b0, 1'b0);
      n_cmp++; if (o_in_ready !== e_in_ready || o_cen !== e_cen || (!e_cen && o_a !== e_a)) begin
        n_fail++; $display("FAIL fill_cmd cyc=%0d got rdy=%0b cen=%0b a=%0d exp rdy=%0b cen=%0b a=%0d",
                            c, o_in_ready, o_cen, o_a, e_in_ready, e_cen, e_a);
      end
      if (o_in_ready) acc++;
    end
    n_cmp++; if (acc != 514) begin n_fail++; $display("FAIL fill_accept_count got=%0d exp=514", acc); end
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    n_cmp++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got=%0b exp=0", o_in_ready); end
    n_cmp++; if (o_level !== 514) begin n_fail++; $display("FAIL fill_level got=%0d exp=514", o_level); end
    n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h00) begin
      n_fail++; $display("FAIL fill_head got valid=%0b data=%h exp 1/00", o_out_valid, o_out_data);
    end
    $display("test_fill done accepted=%0d", acc);
  endtask

  task automatic test_back_to_back();
    logic seen_wr = 1'b0;
    for (int c = 0; c < 150; c++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      if (!o_cen && !o_gwen && !seen_wr) begin
        seen_wr = 1'b1;
        n_cmp++; if (o_a !== 9'd2) begin n_fail++; $display("FAIL b2b_wrapped_wr_ptr got=%0d exp=2", o_a); end
      end
      n_cmp++; if (o_cen !== e_cen || o_gwen !== e_gwen || (!e_cen && o_a !== e_a)) begin
        n_fail++; $display("FAIL b2b_cmd cyc=%0d got cen=%0b gwen=%0b a=%0d exp %0b/%0b/%0d", c, o_cen, o_gwen, o_a, e_cen, e_gwen, e_a);
      end
      n_cmp++; if (o_out_valid !== e_out_valid || (e_out_valid && o_out_data !== e_out_data)) begin
        n_fail++; $display("FAIL b2b_out cyc=%0d got v=%0b d=%h exp v=%0b d=%h", c, o_out_valid, o_out_data, e_out_valid, e_out_data);
      end
      n_cmp++; if (o_level !== e_level) begin n_fail++; $display("FAIL b2b_level cyc=%0d got=%0d exp=%0d", c, o_level, e_level); end
    end
    n_cmp++; if (!seen_wr) begin n_fail++; $display("FAIL b2b_no_write got=0 exp=1"); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    int rd = 0, erd = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      if (e_is_read) erd++;
      if (!o_cen && o_gwen) begin
        rd++;
        n_cmp++; if (e_pend >= 2) begin n_fail++; $display("FAIL stall_read_when_full cyc=%0d got pend=%0d exp<2", c, e_pend); end
      end
      n_cmp++; if (o_level !== e_level) begin n_fail++; $display("FAIL stall_level cyc=%0d got=%0d exp=%0d", c, o_level, e_level); end
    end
    n_cmp++; if (rd != erd || rd > 2) begin n_fail++; $display("FAIL stall_read_count got=%0d exp=%0d (max 2)", rd, erd); end
    $display("test_stall done reads=%0d", rd);
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (o_cen !== 1'b0 || o_gwen !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_read got cen=%0b gwen=%0b exp 0/1", o_cen, o_gwen);
    end
    step(1'b1, 8'h33, 1'b0, 1'b1);
    n_cmp++; if (o_cen !== 1'b1 || o_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle got cen=%0b rdy=%0b exp 1/0", o_cen, o_in_ready);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_level !== 0 || o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_after got level=%0d valid=%0b exp 0/0", o_level, o_out_valid);
    end
    step(1'b1, 8'h22, 1'b1, 1'b0);
    n_cmp++; if (o_cen !== 1'b0 || o_gwen !== 1'b0 || o_a !== 9'd0) begin
      n_fail++; $display("FAIL flush_next_write got cen=%0b gwen=%0b a=%0d exp 0/0/0", o_cen, o_gwen, o_a);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_cen !== 1'b0 || o_gwen !== 1'b1 || o_a !== 9'd0) begin
      n_fail++; $display("FAIL flush_next_read got cen=%0b gwen=%0b a=%0d exp 0/1/0", o_cen, o_gwen, o_a);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== 8'h22) begin
      n_fail++; $display("FAIL flush_next_data got v=%0b d=%h exp 1/22", o_out_valid, o_out_data);
    end
    $display("test_flush done");
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 800; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      fl   = ($urandom_range(0, 149) == 0);
      step(iv, 8'($urandom), ordy, fl);
      n_cmp++; if (o_in_ready !== e_in_ready) begin
        n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", c, o_in_ready, e_in_ready);
      end
      n_cmp++; if (o_cen !== e_cen || o_gwen !== e_gwen || (!e_cen && o_a !== e_a) || (e_is_write && o_d !== e_d)) begin
        n_fail++; $display("FAIL rnd_cmd cyc=%0d got cen=%0b gwen=%0b a=%0d d=%h exp %0b/%0b/%0d/%h",
                            c, o_cen, o_gwen, o_a, o_d, e_cen, e_gwen, e_a, e_d);
      end
      n_cmp++; if (o_out_valid !== e_out_valid || (e_out_valid && o_out_data !== e_out_data)) begin
        n_fail++; $display("FAIL rnd_out cyc=%0d got v=%0b d=%h exp v=%0b d=%h", c, o_out_valid, o_out_data, e_out_valid, e_out_data);
      end
      n_cmp++; if (o_level !== e_level) begin n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, o_level, e_level); end
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 20; c++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || sram_cen !== 1'b1) begin
      n_fail++; $display("FAIL midrst_immediate got rdy=%0b cen=%0b exp 0/1", in_ready, sram_cen);
    end
    n_cmp++; if (level !== 11'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got level=%0d valid=%0b exp 0/0", level, out_valid);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    n_cmp++; if (o_in_ready !== 1'b0 || o_cen !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_cycle got rdy=%0b cen=%0b exp 0/1", o_in_ready, o_cen);
    end
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    n_cmp++; if (o_in_ready !== 1'b1 || o_cen !== 1'b0 || o_gwen !== 1'b0 || o_a !== 9'd0) begin
      n_fail++; $display("FAIL midrst_second_cycle got rdy=%0b cen=%0b gwen=%0b a=%0d exp 1/0/0/0", o_in_ready, o_cen, o_gwen, o_a);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (o_level !== e_level || o_level !== 0) begin
      n_fail++; $display("FAIL midrst_drain got level=%0d exp=%0d", o_level, e_level);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
